// File: rtl/mfp_ahb_interconnect.sv
// ---------------------------------------------------------------------------
// mfp_ahb_interconnect
//
// AHB-lite single-master interconnect for the MIPSfpga platform.
//
// Address phase : HADDR is decoded combinationally against a per-slave
//                 base/mask table into the one-hot HSEL_S. The lowest matching
//                 index wins. An address that matches no slave goes to the
//                 built-in default slave (DS).
// Data phase    : the owner of the data phase (dsel) is registered on every
//                 HCLK edge where HREADY is high. HRDATA/HREADY/HRESP are
//                 muxed from that owner.
// Default slave : answers an unmapped NONSEQ/SEQ transfer with the two-cycle
//                 AHB ERROR response (wait+ERROR, then ready+ERROR). IDLE/BUSY
//                 to an unmapped address gets a zero-wait OKAY. Every
//                 accepted unmapped active transfer bumps a saturating counter
//                 and records its address and direction.
//
// Ports
//   HCLK, HRESETn          clock, synchronous active-low reset
//   HADDR, HTRANS, HWRITE  master address-phase signals
//   HRDATA, HREADY, HRESP  data-phase response to the master
//   HSEL_S                 one-hot slave select (address phase)
//   HRDATA_S, HREADYOUT_S,
//   HRESP_S                per-slave responses, slice i belongs to slave i
//   ERR_CNT, ERR_ADDR,
//   ERR_WR                 unmapped-access statistics
// ---------------------------------------------------------------------------
module mfp_ahb_interconnect #(
    parameter int                  N_SLV    = 4,
    parameter logic [N_SLV*32-1:0] SLV_BASE = {32'h1F400000, 32'h1F800000,
                                               32'h00000000, 32'h1FC00000},
    parameter logic [N_SLV*32-1:0] SLV_MASK = {32'h1FC00000, 32'h1FC00000,
                                               32'h10000000, 32'h1FC00000}
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,

    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,

    output logic [31:0]           HRDATA,
    output logic                  HREADY,
    output logic                  HRESP,

    output logic [N_SLV-1:0]      HSEL_S,
    input  logic [N_SLV*32-1:0]   HRDATA_S,
    input  logic [N_SLV-1:0]      HREADYOUT_S,
    input  logic [N_SLV-1:0]      HRESP_S,

    output logic [15:0]           ERR_CNT,
    output logic [31:0]           ERR_ADDR,
    output logic                  ERR_WR
);

    // Index of the default slave inside the data-phase owner vector.
    localparam int DS = N_SLV;

    if (N_SLV < 1 || N_SLV > 8) begin : g_bad_n_slv
        $error("mfp_ahb_interconnect: N_SLV must be in 1..8");
    end

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    // -----------------------------------------------------------------------
    // Signals
    // -----------------------------------------------------------------------
    logic [N_SLV-1:0] dec_sel;     // address-phase decode, one-hot or zero
    logic             dec_ds;      // address-phase decode hits nothing

    logic [N_SLV:0]   dsel_q;      // data-phase owner, one-hot or zero
    logic [N_SLV:0]   dsel_d;

    ds_state_e        ds_state_q;
    ds_state_e        ds_state_d;
    logic             ds_hready;
    logic             ds_hresp;

    logic             hready_mux;
    logic             hresp_mux;
    logic [31:0]      hrdata_mux;

    logic             err_accept;  // unmapped active transfer accepted this edge

    logic [15:0]      err_cnt_q;
    logic [15:0]      err_cnt_d;
    logic [31:0]      err_addr_q;
    logic [31:0]      err_addr_d;
    logic             err_wr_q;
    logic             err_wr_d;

    // Only NONSEQ/SEQ versus IDLE/BUSY matters here, so HTRANS[0] is unused.
    logic             unused_htrans0;
    assign unused_htrans0 = HTRANS[0];

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    always_comb begin
        logic found;
        // NOTE: every variable written in a combinational block gets a value
        // on entry; a path that leaves one unassigned infers a latch.
        dec_sel = '0;
        found   = 1'b0;
        // Ascending scan with a found flag gives lowest-index priority and
        // guarantees at most one bit set even when table entries overlap.
        for (int i = 0; i < N_SLV; i++) begin
            if (!found && ((HADDR & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32])) begin
                dec_sel[i] = 1'b1;
                found      = 1'b1;
            end
        end
        dec_ds = !found;
    end

    assign HSEL_S = dec_sel;

    // An unmapped transfer only costs an ERROR response when it is active
    // and its address phase is actually accepted.
    assign err_accept = hready_mux && dec_ds && HTRANS[1];

    // -----------------------------------------------------------------------
    // Data-phase owner
    // -----------------------------------------------------------------------
    always_comb begin
        dsel_d = dsel_q;
        if (hready_mux) begin
            dsel_d = {dec_ds, dec_sel};
        end
    end

    always_ff @(posedge HCLK) begin
        // NOTE: registers are written with non-blocking assignments so every
        // flop samples the pre-edge values, independent of block ordering.
        if (!HRESETn) begin
            dsel_q <= '0;
        end else begin
            dsel_q <= dsel_d;
        end
    end

    // -----------------------------------------------------------------------
    // Default-slave FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            ds_state_q <= DS_IDLE;
        end else begin
            ds_state_q <= ds_state_d;
        end
    end

    // Default-slave FSM: next state
    always_comb begin
        ds_state_d = ds_state_q;
        case (ds_state_q)
            DS_IDLE: if (err_accept) ds_state_d = DS_ERR1;
            // HREADY is low in DS_ERR1, so nothing new can be accepted here.
            DS_ERR1: ds_state_d = DS_ERR2;
            // DS_ERR2 completes the transfer; a following unmapped access
            // issued in this cycle starts its own ERROR response immediately.
            DS_ERR2: ds_state_d = err_accept ? DS_ERR1 : DS_IDLE;
            default: ds_state_d = DS_IDLE;
        endcase
    end

    // Default-slave FSM: outputs
    always_comb begin
        ds_hready = 1'b1;
        ds_hresp  = 1'b0;
        case (ds_state_q)
            DS_ERR1: begin
                ds_hready = 1'b0;
                ds_hresp  = 1'b1;
            end
            DS_ERR2: begin
                ds_hready = 1'b1;
                ds_hresp  = 1'b1;
            end
            default: begin
                ds_hready = 1'b1;
                ds_hresp  = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Response mux. With no owner (after reset) the bus reads as an idle,
    // always-ready OKAY so the master's first address phase is accepted.
    // -----------------------------------------------------------------------
    always_comb begin
        hrdata_mux = '0;
        hready_mux = 1'b1;
        hresp_mux  = 1'b0;
        for (int i = 0; i < N_SLV; i++) begin
            if (dsel_q[i]) begin
                hrdata_mux = HRDATA_S[i*32 +: 32];
                hready_mux = HREADYOUT_S[i];
                hresp_mux  = HRESP_S[i];
            end
        end
        if (dsel_q[DS]) begin
            hready_mux = ds_hready;
            hresp_mux  = ds_hresp;
        end
    end

    assign HRDATA = hrdata_mux;
    assign HREADY = hready_mux;
    assign HRESP  = hresp_mux;

    // -----------------------------------------------------------------------
    // Error capture. err_accept is exactly the condition for entering
    // DS_ERR1, so the statistics track the FSM one-for-one.
    // -----------------------------------------------------------------------
    always_comb begin
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        err_wr_d   = err_wr_q;
        if (err_accept) begin
            err_addr_d = HADDR;
            err_wr_d   = HWRITE;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            err_wr_q   <= 1'b0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
            err_wr_q   <= err_wr_d;
        end
    end

    assign ERR_CNT  = err_cnt_q;
    assign ERR_ADDR = err_addr_q;
    assign ERR_WR   = err_wr_q;

endmodule

// File: tb/tb_mfp_ahb_interconnect.sv
// ---------------------------------------------------------------------------
// tb_mfp_ahb_interconnect
//
// Bench for mfp_ahb_interconnect with its default 4-slave map.
// Inputs change at the falling edge; outputs are sampled 1 ns later, well
// before the next rising edge that consumes them.
//   1. A table of directed cycles with hand-derived expectations.
//   2. Reset in the middle of an ERROR response.
//   3. Randomised traffic compared against a transaction-level model.
//   4. Error-counter saturation.
// ---------------------------------------------------------------------------
module tb_mfp_ahb_interconnect;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam int         NS     = 4;

    // Address map, slave index order.
    localparam logic [31:0] MAP_BASE [NS] = '{32'h1FC00000, 32'h00000000,
                                              32'h1F800000, 32'h1F400000};
    localparam logic [31:0] MAP_MASK [NS] = '{32'h1FC00000, 32'h10000000,
                                              32'h1FC00000, 32'h1FC00000};

    logic          HCLK;
    logic          HRESETn;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [31:0]   HRDATA;
    logic          HREADY;
    logic          HRESP;
    logic [NS-1:0] HSEL_S;
    logic [127:0]  HRDATA_S;
    logic [NS-1:0] HREADYOUT_S;
    logic [NS-1:0] HRESP_S;
    logic [15:0]   ERR_CNT;
    logic [31:0]   ERR_ADDR;
    logic          ERR_WR;

    int n_vec = 0;
    int n_err = 0;

    mfp_ahb_interconnect dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HSEL_S      (HSEL_S),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .ERR_CNT     (ERR_CNT),
        .ERR_ADDR    (ERR_ADDR),
        .ERR_WR      (ERR_WR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_hsel, input logic [31:0] e_rdata,
                             input logic e_ready, input logic e_resp, input logic [15:0] e_cnt,
                             input logic [31:0] e_eaddr, input logic e_ewr);
        check({tag, " HSEL_S"},   32'(HSEL_S),   32'(e_hsel));
        check({tag, " HRDATA"},   HRDATA,        e_rdata);
        check({tag, " HREADY"},   32'(HREADY),   32'(e_ready));
        check({tag, " HRESP"},    32'(HRESP),    32'(e_resp));
        check({tag, " ERR_CNT"},  32'(ERR_CNT),  32'(e_cnt));
        check({tag, " ERR_ADDR"}, ERR_ADDR,      e_eaddr);
        check({tag, " ERR_WR"},   32'(ERR_WR),   32'(e_ewr));
    endtask

    task automatic apply(input logic rst, input logic [1:0] tr, input logic [31:0] a,
                         input logic w, input logic [3:0] rdy, input logic [3:0] rsp,
                         input logic [127:0] rd);
        @(negedge HCLK);
        HRESETn     = rst;
        HTRANS      = tr;
        HADDR       = a;
        HWRITE      = w;
        HREADYOUT_S = rdy;
        HRESP_S     = rsp;
        HRDATA_S    = rd;
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Reference model: who owns the data phase and how far into the two-cycle
    // ERROR response the default slave is.
    // -----------------------------------------------------------------------
    int          m_owner;   // -1 none, 0..NS-1 slave, NS default slave
    int          m_err;     // 0 no error response, 1 first cycle, 2 second
    logic [15:0] m_cnt;
    logic [31:0] m_eaddr;
    logic        m_ewr;

    function automatic int model_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & MAP_MASK[i]) == MAP_BASE[i]) return i;
        end
        return NS;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_err   = 0;
        m_cnt   = '0;
        m_eaddr = '0;
        m_ewr   = 1'b0;
    endtask

    task automatic model_expect(output logic [3:0] hsel, output logic [31:0] rd,
                                output logic rdy, output logic rsp);
        int d;
        d    = model_decode(HADDR);
        hsel = '0;
        if (d < NS) hsel[d] = 1'b1;
        if (m_owner < 0) begin
            rd = '0; rdy = 1'b1; rsp = 1'b0;
        end else if (m_owner < NS) begin
            rd  = HRDATA_S[m_owner*32 +: 32];
            rdy = HREADYOUT_S[m_owner];
            rsp = HRESP_S[m_owner];
        end else begin
            rd  = '0;
            rdy = (m_err != 1);
            rsp = (m_err != 0);
        end
    endtask

    task automatic model_step(input logic ready_now);
        int d;
        if (!HRESETn) begin
            model_reset();
        end else if (ready_now) begin
            d       = model_decode(HADDR);
            m_owner = d;
            if (d == NS && HTRANS[1]) begin
                m_err   = 1;
                m_eaddr = HADDR;
                m_ewr   = HWRITE;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else begin
                m_err = 0;
            end
        end else if (m_owner == NS && m_err == 1) begin
            m_err = 2;
        end
    endtask

    // -----------------------------------------------------------------------
    // Directed table
    // -----------------------------------------------------------------------
    typedef struct {
        logic        rst_n;
        logic        chk;
        logic [1:0]  htrans;
        logic [31:0] haddr;
        logic        hwrite;
        logic [3:0]  hrdy_s;
        logic [3:0]  hresp_s;
        logic [3:0]  e_hsel;
        logic [31:0] e_rdata;
        logic        e_ready;
        logic        e_resp;
        logic [15:0] e_cnt;
        logic [31:0] e_eaddr;
        logic        e_ewr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic c, input logic [1:0] t,
                                input logic [31:0] a, input logic w, input logic [3:0] rdy,
                                input logic [3:0] rsp, input logic [3:0] hs, input logic [31:0] rd,
                                input logic er, input logic es, input logic [15:0] cn,
                                input logic [31:0] ea, input logic ew);
        vec_t v;
        v.rst_n = r;  v.chk = c;  v.htrans = t;  v.haddr = a;  v.hwrite = w;
        v.hrdy_s = rdy;  v.hresp_s = rsp;  v.e_hsel = hs;  v.e_rdata = rd;
        v.e_ready = er;  v.e_resp = es;  v.e_cnt = cn;  v.e_eaddr = ea;  v.e_ewr = ew;
        return v;
    endfunction

    localparam logic [127:0] TBL_RDATA = {32'h33333333, 32'h22222222,
                                          32'h11111111, 32'hDEADBEEF};

    initial begin
        logic [3:0]   e_hsel;
        logic [31:0]  e_rd;
        logic         e_rdy;
        logic         e_rsp;
        logic [127:0] rd;
        logic [31:0]  a;

        HRESETn = 1'b0; HTRANS = IDLE; HADDR = '0; HWRITE = 1'b0;
        HREADYOUT_S = '1; HRESP_S = '0; HRDATA_S = '0;

        //            rst chk htrans  haddr         wr rdy    rsp     hsel    rdata         rdy es cnt ERR_ADDR     ewr
        tbl.push_back(mk(0, 0, IDLE,   32'h1F000000, 0, 4'hF, 4'h0, 4'h0, 32'h0,        1, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 1, IDLE,   32'h1F000000, 0, 4'hF, 4'h0, 4'h0, 32'h0,        1, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1, 1, IDLE,   32'h1F000000, 0, 4'hF, 4'h0, 4'h0, 32'h0,        1, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1, 1, NONSEQ, 32'h1FC00010, 0, 4'hF, 4'h0, 4'h1, 32'h0,        1, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1, 1, NONSEQ, 32'h00001000, 0, 4'hF, 4'h0, 4'h2, 32'hDEADBEEF, 1, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1, 1, NONSEQ, 32'h1F800004, 0, 4'hF, 4'h0, 4'h4, 32'h11111111, 1, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1, 1, NONSEQ, 32'h1F400000, 0, 4'hB, 4'h0, 4'h8, 32'h22222222, 0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1, 1, NONSEQ, 32'h1F400000, 0, 4'hB, 4'h0, 4'h8, 32'h22222222, 0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1, 1, NONSEQ, 32'h1F400000, 0, 4'hB, 4'h0, 4'h8, 32'h22222222, 0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1, 1, NONSEQ, 32'h1F400000, 0, 4'hF, 4'h0, 4'h8, 32'h22222222, 1, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1, 1, NONSEQ, 32'h1F000000, 1, 4'hF, 4'h0, 4'h0, 32'h33333333, 1, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1, 1, IDLE,   32'h1F000000, 0, 4'hF, 4'h0, 4'h0, 32'h0,        0, 1, 1, 32'h1F000000, 1));
        tbl.push_back(mk(1, 1, IDLE,   32'h1F000000, 0, 4'hF, 4'h0, 4'h0, 32'h0,        1, 1, 1, 32'h1F000000, 1));
        tbl.push_back(mk(1, 1, IDLE,   32'h1F000000, 0, 4'hF, 4'h0, 4'h0, 32'h0,        1, 0, 1, 32'h1F000000, 1));
        tbl.push_back(mk(1, 1, NONSEQ, 32'h1F000004, 0, 4'hF, 4'h0, 4'h0, 32'h0,        1, 0, 1, 32'h1F000000, 1));
        tbl.push_back(mk(1, 1, SEQ,    32'h1F000008, 1, 4'hF, 4'h0, 4'h0, 32'h0,        0, 1, 2, 32'h1F000004, 0));
        tbl.push_back(mk(1, 1, SEQ,    32'h1F000008, 1, 4'hF, 4'h0, 4'h0, 32'h0,        1, 1, 2, 32'h1F000004, 0));
        tbl.push_back(mk(1, 1, IDLE,   32'h1FC00000, 0, 4'hF, 4'h0, 4'h1, 32'h0,        0, 1, 3, 32'h1F000008, 1));
        tbl.push_back(mk(1, 1, IDLE,   32'h1FC00000, 0, 4'hF, 4'h0, 4'h1, 32'h0,        1, 1, 3, 32'h1F000008, 1));
        tbl.push_back(mk(1, 1, IDLE,   32'h1FC00000, 0, 4'hF, 4'h0, 4'h1, 32'hDEADBEEF, 1, 0, 3, 32'h1F000008, 1));
        tbl.push_back(mk(1, 1, IDLE,   32'h1FC00000, 0, 4'hF, 4'h1, 4'h1, 32'hDEADBEEF, 1, 1, 3, 32'h1F000008, 1));
        tbl.push_back(mk(1, 1, IDLE,   32'h1FC00000, 0, 4'h7, 4'h0, 4'h1, 32'hDEADBEEF, 1, 0, 3, 32'h1F000008, 1));

        // ---- 1. directed table ----
        foreach (tbl[k]) begin
            apply(tbl[k].rst_n, tbl[k].htrans, tbl[k].haddr, tbl[k].hwrite,
                  tbl[k].hrdy_s, tbl[k].hresp_s, TBL_RDATA);
            if (tbl[k].chk) begin
                check_all($sformatf("tbl[%0d]", k), tbl[k].e_hsel, tbl[k].e_rdata, tbl[k].e_ready,
                          tbl[k].e_resp, tbl[k].e_cnt, tbl[k].e_eaddr, tbl[k].e_ewr);
            end
        end

        // ---- 2. reset while the default slave is in its first ERROR cycle ----
        apply(1, NONSEQ, 32'h1F000000, 1, 4'hF, 4'h0, TBL_RDATA);
        check("rst_err accept HREADY", 32'(HREADY), 32'd1);
        apply(0, IDLE, 32'h1FC00000, 0, 4'hF, 4'h0, TBL_RDATA);
        check("rst_err ERR1 HREADY", 32'(HREADY), 32'd0);
        check("rst_err ERR1 HRESP", 32'(HRESP), 32'd1);
        check("rst_err ERR1 ERR_CNT", 32'(ERR_CNT), 32'd4);
        apply(1, NONSEQ, 32'h1F000000, 0, 4'hF, 4'h0, TBL_RDATA);
        check_all("rst_err after", 4'h0, 32'h0, 1'b1, 1'b0, 16'h0, 32'h0, 1'b0);
        apply(1, IDLE, 32'h1FC00000, 0, 4'hF, 4'h0, TBL_RDATA);
        check_all("rst_err new ERR1", 4'h1, 32'h0, 1'b0, 1'b1, 16'h1, 32'h1F000000, 1'b0);

        // ---- 3. random traffic against the model ----
        apply(0, IDLE, 32'h0, 0, 4'hF, 4'h0, TBL_RDATA);
        model_reset();
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 5))
                0:       a = 32'h1FC00000 | ($urandom & 32'h003FFFFF);
                1:       a = $urandom & 32'hEFFFFFFF;
                2:       a = 32'h1F800000 | ($urandom & 32'h003FFFFF);
                3:       a = 32'h1F400000 | ($urandom & 32'h003FFFFF);
                4:       a = 32'h1F000000 | ($urandom & 32'h003FFFFF);
                default: a = $urandom;
            endcase
            rd = {$urandom, $urandom, $urandom, $urandom};
            apply(($urandom_range(0, 49) != 0), 2'($urandom_range(0, 3)), a, 1'($urandom),
                  {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)},
                  {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)}, rd);
            model_expect(e_hsel, e_rd, e_rdy, e_rsp);
            check_all($sformatf("rnd[%0d]", n), e_hsel, e_rd, e_rdy, e_rsp, m_cnt, m_eaddr, m_ewr);
            model_step(e_rdy);
        end

        // ---- 4. error counter saturation ----
        apply(0, IDLE, 32'h1FC00000, 0, 4'hF, 4'h0, TBL_RDATA);
        apply(1, IDLE, 32'h1FC00000, 0, 4'hF, 4'h0, TBL_RDATA);
        force dut.err_cnt_q = 16'hFFFE;
        #1;
        release dut.err_cnt_q;
        apply(1, NONSEQ, 32'h1F000000, 0, 4'hF, 4'h0, TBL_RDATA);
        check("sat preload ERR_CNT", 32'(ERR_CNT), 32'h0000FFFE);
        apply(1, IDLE, 32'h1FC00000, 0, 4'hF, 4'h0, TBL_RDATA);
        check("sat first ERR_CNT", 32'(ERR_CNT), 32'h0000FFFF);
        check("sat first HREADY", 32'(HREADY), 32'd0);
        apply(1, NONSEQ, 32'h1F000010, 1, 4'hF, 4'h0, TBL_RDATA);
        check("sat ERR2 HREADY", 32'(HREADY), 32'd1);
        check("sat ERR2 HRESP", 32'(HRESP), 32'd1);
        apply(1, IDLE, 32'h1FC00000, 0, 4'hF, 4'h0, TBL_RDATA);
        check("sat hold ERR_CNT", 32'(ERR_CNT), 32'h0000FFFF);
        check("sat hold ERR_ADDR", ERR_ADDR, 32'h1F000010);
        check("sat hold ERR_WR", 32'(ERR_WR), 32'd1);
        check("sat hold HREADY", 32'(HREADY), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mfp_ahb_interconnect.md
Name: mfp_ahb_interconnect

Overview:
- Parametrised AHB-lite single-master interconnect for the MIPSfpga platform; successor to the fixed 4-slave decoder/read-mux.
- Decodes the address phase into one-hot slave selects from a per-slave base/mask table, and registers the data-phase owner.
- Muxes HRDATA, HREADY and HRESP from N_SLV slaves, so slave wait states and error responses are supported.
- Contains a built-in default slave that answers unmapped accesses with a two-cycle AHB ERROR, plus error counter and error address capture.

Parameters:
- N_SLV, 4, number of attached slaves (1..8).
- SLV_BASE, {32'h1F400000, 32'h1F800000, 32'h00000000, 32'h1FC00000}, packed N_SLV*32; slice i is the base of slave i.
- SLV_MASK, {32'h1FC00000, 32'h1FC00000, 32'h10000000, 32'h1FC00000}, packed N_SLV*32; slice i is the compare mask of slave i.

Ports:
- HCLK  in  1  system clock.
- HRESETn  in  1  reset; synchronous, active-low.
- HADDR  in  32  master address.
- HTRANS  in  2  master transfer type.
- HWRITE  in  1  master write flag, used only for error capture.
- HRDATA  out  32  read data to master.
- HREADY  out  1  ready to master; also broadcast to slaves.
- HRESP  out  1  response to master (0 = OKAY, 1 = ERROR).
- HSEL_S  out  N_SLV  one-hot address-phase slave select.
- HRDATA_S  in  N_SLV*32  slave read data; slice i belongs to slave i.
- HREADYOUT_S  in  N_SLV  per-slave ready.
- HRESP_S  in  N_SLV  per-slave response.
- ERR_CNT  out  16  saturating count of unmapped active transfers.
- ERR_ADDR  out  32  HADDR of the most recent unmapped active transfer.
- ERR_WR  out  1  HWRITE of the most recent unmapped active transfer.

Behaviour:
- Decode (combinational): match_i = ((HADDR & MASK_i) == BASE_i).
  - Lowest matching index wins on overlap; HSEL_S is strictly one-hot or zero.
  - HSEL_S does not depend on HTRANS; slaves qualify with HTRANS[1].
  - No match means the default slave (DS) is selected internally.
- Data-phase owner dsel: one-hot over N_SLV+1 (bit N_SLV = DS).
  - Loaded from the decode on every HCLK edge where HREADY==1.
  - Holds while HREADY==0.
  - Reset value is all-zero ("none").
- Output mux:
  - dsel = slave i: HRDATA = HRDATA_S[i], HREADY = HREADYOUT_S[i], HRESP = HRESP_S[i].
  - dsel = none: HRDATA = 0, HREADY = 1, HRESP = 0.
  - dsel = DS: HRDATA = 0; HREADY and HRESP come from the DS FSM.
- DS FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE -> DS_ERR1 on an edge with HREADY==1, decode = DS and HTRANS[1]==1 (NONSEQ/SEQ).
  - DS_ERR1 drives HREADY=0, HRESP=1; always -> DS_ERR2 next cycle.
  - DS_ERR2 drives HREADY=1, HRESP=1.
    - -> DS_ERR1 if a new unmapped active transfer is accepted this edge.
    - -> DS_IDLE otherwise.
  - DS_IDLE with dsel = DS (an IDLE/BUSY transfer to an unmapped address): HREADY=1, HRESP=0, zero wait.
- Error capture, on each transition into DS_ERR1:
  - ERR_ADDR <= HADDR, ERR_WR <= HWRITE.
  - ERR_CNT increments and saturates at 16'hFFFF (no wrap).
- Back-to-back transfers:
  - A new address phase is accepted in the same cycle a previous data phase completes (HREADY==1), including the DS_ERR2 cycle.
  - HSEL_S always reflects the current HADDR.
- Reset: synchronous reset on an HCLK edge with HRESETn==0, including mid-wait-state or mid-error.
  - dsel = none, FSM = DS_IDLE, ERR_CNT = 0, ERR_ADDR = 0, ERR_WR = 0.
  - Next cycle: HREADY=1, HRESP=0, HRDATA=0. HSEL_S stays combinational.
- Latency: decode is 0 cycles; a mapped read returns data in the data phase with slave-inserted wait states only; an unmapped active transfer takes exactly 2 data-phase cycles.

Test Plan:
- After reset, master holds HTRANS=IDLE -> HREADY=1, HRESP=0, HRDATA=0, ERR_CNT=0.
- NONSEQ read HADDR=0x1FC00010, slave0 HRDATA_S[0]=0xDEADBEEF -> HSEL_S=4'b0001 in the address phase; HRDATA=0xDEADBEEF, HREADY=1 next cycle. HADDR=0x00001000 -> HSEL_S=4'b0010.
- NONSEQ read to slave2 (0x1F800004) with HREADYOUT_S[2] low for 3 cycles -> HREADY low exactly 3 cycles; next address (0x1F400000) not latched until HREADY=1; dsel stays slave2.
- NONSEQ write to 0x1F000000 (unmapped) -> HREADY=0/HRESP=1, then HREADY=1/HRESP=1; ERR_CNT=1, ERR_ADDR=0x1F000000, ERR_WR=1. An IDLE to the same address -> zero-wait OKAY, ERR_CNT unchanged.
- Two consecutive unmapped NONSEQ transfers, the second issued during DS_ERR2 -> pattern ERR1, ERR2, ERR1, ERR2; ERR_CNT=2. Preload ERR_CNT to 0xFFFF -> remains 0xFFFF after a further error.
- HRESETn low for one edge while in DS_ERR1 -> next cycle HREADY=1, HRESP=0, ERR_CNT=0, FSM in DS_IDLE.
